// File: rtl/bgm_pkg.sv
// Purpose: shared constants, state type and melody table for the background-music path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bgm_pkg;

  localparam int NOTE_W   = 5;
  localparam int ADDR_W   = 6;
  localparam int SONG_LEN = 64;

  // The address register must be able to hold SONG_LEN itself while the
  // final entry is sounding, so it carries one bit more than the ROM index.
  localparam int ADDR_CNT_W = ADDR_W + 1;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam logic [NOTE_W-1:0] MELODY [SONG_LEN] = '{
    5'd0,  5'd3,  5'd3,  5'd3,  5'd5,  5'd5,  5'd5,  5'd6,
    5'd8,  5'd8,  5'd8,  5'd6,  5'd6,  5'd6,  5'd6,  5'd12,
    5'd12, 5'd12, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd9,
    5'd9,  5'd9,  5'd9,  5'd9,  5'd9,  5'd9,  5'd9,  5'd9,
    5'd9,  5'd9,  5'd10, 5'd7,  5'd7,  5'd6,  5'd6,  5'd5,
    5'd5,  5'd5,  5'd6,  5'd8,  5'd8,  5'd9,  5'd9,  5'd3,
    5'd3,  5'd8,  5'd8,  5'd8,  5'd5,  5'd5,  5'd8,  5'd5,
    5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5
  };

endpackage

// File: rtl/song_rom.sv
// Purpose: combinational melody lookup from the package table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: addr - melody index; note_code - note at that index (rest if out of range).
module song_rom
  import bgm_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [NOTE_W-1:0] note_code
);

  always_comb begin
    note_code = NOTE_REST;
    if (int'(addr) < SONG_LEN) begin
      note_code = MELODY[addr];
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Purpose: step through the melody one entry per beat; start/pause/loop control.
// Latency: note/strobe registered; start is reflected on the same clock edge it is sampled.
// Backpressure: none; the tone generator must accept a note on every strobe.
// Ports: clk/resetn; start, pause, loop_en controls; note + note_strobe per beat;
//        address = next entry to emit; playing = in PLAY; song_done = pulse on song end.
module note_sequencer
  import bgm_pkg::*;
#(
  parameter int TICK_DIV = 12500000
)
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  loop_en,
  output logic [NOTE_W-1:0]     note,
  output logic                  note_strobe,
  output logic [ADDR_CNT_W-1:0] address,
  output logic                  playing,
  output logic                  song_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_CNT_W-1:0] ADDR_END  = ADDR_CNT_W'(SONG_LEN);
  localparam logic [ADDR_CNT_W-1:0] ADDR_ONE  = ADDR_CNT_W'(1);

  seq_state_e            state_q, state_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic                  strobe_q, strobe_d;
  logic [ADDR_CNT_W-1:0] address_q, address_d;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic                  playing_q, playing_d;
  logic                  done_q, done_d;

  logic [ADDR_W-1:0]     rom_addr;
  logic [NOTE_W-1:0]     rom_note;

  // A single ROM port serves every load: a (re)start and a loop wrap both
  // fetch entry 0, otherwise the next entry is fetched.
  assign rom_addr = (start || (address_q == ADDR_END)) ? '0 : address_q[ADDR_W-1:0];

  song_rom u_song_rom (
    .addr      (rom_addr),
    .note_code (rom_note)
  );

  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    strobe_d  = 1'b0;
    address_d = address_q;
    tick_d    = tick_q;
    done_d    = 1'b0;

    if (start) begin
      // Start wins over pause and over a tick landing on the same edge.
      state_d   = PLAY;
      note_d    = rom_note;
      strobe_d  = 1'b1;
      address_d = ADDR_ONE;
      tick_d    = '0;
    end else begin
      case (state_q)
        PLAY, PAUSED: begin
          if (pause) begin
            // Counter freezes, including at TICK_LAST, so the beat in
            // progress resumes with its remaining length intact.
            state_d = PAUSED;
          end else begin
            // The resume edge counts as an active cycle as well.
            state_d = PLAY;
            if (tick_q == TICK_LAST) begin
              tick_d   = '0;
              strobe_d = 1'b1;
              if (address_q < ADDR_END) begin
                note_d    = rom_note;
                address_d = address_q + 1'b1;
              end else if (loop_en) begin
                note_d    = rom_note;
                address_d = ADDR_ONE;
              end else begin
                note_d    = NOTE_REST;
                done_d    = 1'b1;
                state_d   = DONE;
                // Nothing left to emit; park the index at the song head.
                address_d = '0;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything until start.
        end
      endcase
    end

    playing_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      note_q    <= NOTE_REST;
      strobe_q  <= 1'b0;
      address_q <= '0;
      tick_q    <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      strobe_q  <= strobe_d;
      address_q <= address_d;
      tick_q    <= tick_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign note        = note_q;
  assign note_strobe = strobe_q;
  assign address     = address_q;
  assign playing     = playing_q;
  assign song_done   = done_q;

endmodule
